// File: rtl/rv32m_muldiv_seq_if.sv
// Request/result handshake bundle for the rv32m_muldiv_seq M-extension execute unit.
// The pipeline side uses master; the unit itself uses slave.
interface rv32m_muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            iVALID;
   logic            oREADY;
   logic [31:0]     iIR;
   logic [XLEN-1:0] iALU_IN1;
   logic [XLEN-1:0] iALU_IN2;
   logic            oVALID;
   logic            iREADY;
   logic [4:0]      oRD;
   logic [XLEN-1:0] oALU_OUT;
   logic            oBUSY;

   modport slave (
      input  iVALID, iIR, iALU_IN1, iALU_IN2, iREADY,
      output oREADY, oVALID, oRD, oALU_OUT, oBUSY
   );

   modport master (
      output iVALID, iIR, iALU_IN1, iALU_IN2, iREADY,
      input  oREADY, oVALID, oRD, oALU_OUT, oBUSY
   );
endinterface

// File: rtl/rv32m_muldiv_seq.sv
// Multi-cycle RV32M/RV64M unit: fixed-latency multiply, radix-2 restoring divide.
// Optional macro RV32M_EARLY_OUT_EN lets |dividend| < |divisor| finish in one cycle.
module rv32m_muldiv_seq #(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic              iCLK,
   input  logic              iRST,
   rv32m_muldiv_seq_if.slave bus
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      f3_q, f3_d;
   logic [4:0]      rd_q, rd_d;
   // Multiply: opa/opb are the raw operands. Divide: opa is the dividend/quotient
   // shift register and opb the divisor magnitude.
   logic [XLEN-1:0] opa_q, opa_d;
   logic [XLEN-1:0] opb_q, opb_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic [XLEN-1:0] result_q, result_d;

   // Full 2*XLEN product with per-op operand sign extension.
   function automatic logic [XLEN-1:0] mul_fn(input logic [2:0] f3,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] ea, eb, p;
      logic sa, sb;
      sa = a[XLEN-1] & ((f3[1:0] == 2'b01) | (f3[1:0] == 2'b10));
      sb = b[XLEN-1] & (f3[1:0] == 2'b01);
      ea = {{XLEN{sa}}, a};
      eb = {{XLEN{sb}}, b};
      p  = ea * eb;
      return (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
   endfunction

   logic [2:0]      in_f3;
   logic            in_is_m, in_signed, in_a_neg, in_b_neg;
   logic            in_div_zero, in_div_ovf;
   logic [XLEN-1:0] in_mag_a, in_mag_b;
   logic            accept;
   logic            unused_ir;

   assign in_f3       = bus.iIR[14:12];
   assign in_is_m     = (bus.iIR[31:25] == 7'h01);
   assign in_signed   = ~in_f3[0];
   assign in_a_neg    = in_signed & bus.iALU_IN1[XLEN-1];
   assign in_b_neg    = in_signed & bus.iALU_IN2[XLEN-1];
   assign in_mag_a    = in_a_neg ? -bus.iALU_IN1 : bus.iALU_IN1;
   assign in_mag_b    = in_b_neg ? -bus.iALU_IN2 : bus.iALU_IN2;
   assign in_div_zero = (bus.iALU_IN2 == '0);
   assign in_div_ovf  = in_signed && (bus.iALU_IN1 == MOST_NEG) && (bus.iALU_IN2 == '1);
   assign accept      = bus.iVALID && (state_q == S_IDLE);
   assign unused_ir   = ^{bus.iIR[24:15], bus.iIR[6:0]};

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   logic [XLEN+1:0] div_shift, div_diff;
   logic            div_ge;
   logic [XLEN:0]   rem_nx;
   logic [XLEN-1:0] quo_nx, rem_lo, quo_fix, rem_fix;

   always_comb begin
      div_shift = {rem_q, opa_q[XLEN-1]};
      div_diff  = div_shift - {2'b00, opb_q};
      div_ge    = ~div_diff[XLEN+1];
      rem_nx    = div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
      quo_nx    = {opa_q[XLEN-2:0], div_ge};
      rem_lo    = rem_nx[XLEN-1:0];
      quo_fix   = neg_quo_q ? -quo_nx : quo_nx;
      rem_fix   = neg_rem_q ? -rem_lo : rem_lo;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               f3_d  = in_f3;
               rd_d  = bus.iIR[11:7];
               opa_d = bus.iALU_IN1;
               opb_d = bus.iALU_IN2;
               if (!in_is_m) begin
                  result_d = '0;
                  state_d  = S_DONE;
               end else if (!in_f3[2]) begin
                  if (MUL_LATENCY == 1) begin
                     result_d = mul_fn(in_f3, bus.iALU_IN1, bus.iALU_IN2);
                     state_d  = S_DONE;
                  end else begin
                     cnt_d   = CW'(MUL_LATENCY - 1);
                     state_d = S_MUL;
                  end
               end else if (in_div_zero) begin
                  result_d = in_f3[1] ? bus.iALU_IN1 : '1;
                  state_d  = S_DONE;
               end else if (in_div_ovf) begin
                  result_d = in_f3[1] ? '0 : bus.iALU_IN1;
                  state_d  = S_DONE;
`ifdef RV32M_EARLY_OUT_EN
               end else if (in_mag_a < in_mag_b) begin
                  result_d = in_f3[1] ? bus.iALU_IN1 : '0;
                  state_d  = S_DONE;
`endif
               end else begin
                  cnt_d     = CW'(XLEN);
                  opa_d     = in_mag_a;
                  opb_d     = in_mag_b;
                  rem_d     = '0;
                  neg_quo_d = in_a_neg ^ in_b_neg;
                  neg_rem_d = in_a_neg;
                  state_d   = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (cnt_q == CW'(1)) begin
               result_d = mul_fn(f3_q, opa_q, opb_q);
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            rem_d = rem_nx;
            opa_d = quo_nx;
            cnt_d = cnt_q - CW'(1);
            // Last iteration lands directly in DONE with the sign fix-up applied.
            if (cnt_q == CW'(1)) begin
               result_d = f3_q[1] ? rem_fix : quo_fix;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.iREADY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign bus.oREADY   = (state_q == S_IDLE);
   assign bus.oBUSY    = (state_q != S_IDLE);
   assign bus.oVALID   = (state_q == S_DONE);
   assign bus.oALU_OUT = result_q;
   assign bus.oRD      = rd_q;

endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// Directed plus randomized check of rv32m_muldiv_seq against a plain-arithmetic M-extension model.
module tb_rv32m_muldiv_seq;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rv32m_muldiv_seq_if #(.XLEN(XLEN)) bus();
   rv32m_muldiv_seq #(.XLEN(XLEN), .MUL_LATENCY(2)) dut (
      .iCLK(clk),
      .iRST(rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      if (f7 != 7'h01) return 32'h0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      if (f7 != 7'h01) return 1;
      if (!f3[2]) return 2;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      ma = f3[0] ? longint'({32'b0, a}) : longint'($signed(a));
      mb = f3[0] ? longint'({32'b0, b}) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef RV32M_EARLY_OUT_EN
      if (ma < mb) return 1;
`endif
      return 33;
   endfunction

   task automatic wait_ready(input string tag);
      int w = 0;
      while (!bus.oREADY && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w >= 200) check({tag, "_ready_timeout"}, 64'(bus.oREADY), 64'h1);
   endtask

   // Issue one op at a negedge; return measured latency (accept edge to first oVALID).
   task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, output int lat);
      bus.iVALID   = 1'b1;
      bus.iIR      = {f7, 5'($urandom), 5'($urandom), f3, rd, 7'h33};
      bus.iALU_IN1 = a;
      bus.iALU_IN2 = b;
      @(posedge clk);
      @(negedge clk);
      bus.iVALID   = 1'b0;
      bus.iIR      = $urandom;
      bus.iALU_IN1 = $urandom;
      bus.iALU_IN2 = $urandom;
      lat = 1;
      while (!bus.oVALID && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic retire(input string tag);
      bus.iREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.iREADY = 1'b0;
      check({tag, "_vld_drop"}, 64'(bus.oVALID), 64'h0);
      check({tag, "_rdy_back"}, 64'(bus.oREADY), 64'h1);
   endtask

   task automatic run_op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
      int lat;
      logic [4:0] rd;
      rd = 5'($urandom);
      wait_ready(tag);
      issue(f7, f3, rd, a, b, lat);
      check({tag, "_lat"}, 64'(lat), 64'(ref_lat(f7, f3, a, b)));
      check({tag, "_res"}, 64'(bus.oALU_OUT), 64'(ref_res(f7, f3, a, b)));
      check({tag, "_rd"},  64'(bus.oRD), 64'(rd));
      check({tag, "_busy"}, 64'(bus.oBUSY), 64'h1);
      retire(tag);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int lat;
      logic [31:0] held_res;
      logic [4:0]  held_rd;
      logic [6:0]  f7;
      rst          = 1'b1;
      bus.iVALID   = 1'b0;
      bus.iREADY   = 1'b0;
      bus.iIR      = '0;
      bus.iALU_IN1 = '0;
      bus.iALU_IN2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 64'(bus.oREADY), 64'h1);
      check("rst_valid", 64'(bus.oVALID), 64'h0);
      check("rst_out",   64'(bus.oALU_OUT), 64'h0);
      check("rst_rd",    64'(bus.oRD), 64'h0);
      check("rst_busy",  64'(bus.oBUSY), 64'h0);

      // Test plan directed cases.
      run_op("mul",     7'h01, 3'd0, 32'd7, 32'hFFFF_FFFD);
      check("mul_const", 64'(ref_res(7'h01, 3'd0, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB);
      run_op("mulh",    7'h01, 3'd1, 32'h8000_0000, 32'h8000_0000);
      run_op("mulhsu",  7'h01, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhu",   7'h01, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div",     7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op("rem",     7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op("divu",    7'h01, 3'd5, 32'd100, 32'd7);
      run_op("remu",    7'h01, 3'd7, 32'd100, 32'd7);
      run_op("divu0",   7'h01, 3'd5, 32'd5, 32'd0);
      run_op("remu0",   7'h01, 3'd7, 32'd5, 32'd0);
      run_op("divovf",  7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("removf",  7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_sm", 7'h01, 3'd5, 32'd3, 32'd10);
      run_op("remu_sm", 7'h01, 3'd7, 32'd3, 32'd10);
      run_op("rem_neg", 7'h01, 3'd6, 32'hFFFF_FFFD, 32'd10);
      run_op("nonm",    7'h00, 3'd0, 32'd9, 32'd9);

      // Backpressure: result must hold while iREADY is low and new requests are ignored.
      wait_ready("bp");
      issue(7'h01, 3'd0, 5'd17, 32'd6, 32'd5, lat);
      check("bp_lat", 64'(lat), 64'd2);
      held_res = bus.oALU_OUT;
      held_rd  = bus.oRD;
      check("bp_res", 64'(held_res), 64'd30);
      for (int i = 0; i < 5; i++) begin
         bus.iVALID   = 1'b1;
         bus.iIR      = {7'h01, 10'h0, 3'd4, 5'd3, 7'h33};
         bus.iALU_IN1 = $urandom;
         bus.iALU_IN2 = $urandom;
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_vld", 64'(bus.oVALID), 64'h1);
         check("bp_hold_res", 64'(bus.oALU_OUT), 64'(held_res));
         check("bp_hold_rd",  64'(bus.oRD), 64'(held_rd));
         check("bp_hold_rdy", 64'(bus.oREADY), 64'h0);
      end
      bus.iVALID = 1'b0;
      retire("bp");

      // Reset in the middle of a divide discards it.
      wait_ready("rstdiv");
      bus.iVALID   = 1'b1;
      bus.iIR      = {7'h01, 10'h0, 3'd5, 5'd9, 7'h33};
      bus.iALU_IN1 = 32'd1000;
      bus.iALU_IN2 = 32'd3;
      @(posedge clk);
      @(negedge clk);
      bus.iVALID = 1'b0;
      repeat (9) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("rstdiv_busy", 64'(bus.oBUSY), 64'h1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rstdiv_vld", 64'(bus.oVALID), 64'h0);
      check("rstdiv_rdy", 64'(bus.oREADY), 64'h1);
      check("rstdiv_out", 64'(bus.oALU_OUT), 64'h0);
      run_op("post_rst_mul", 7'h01, 3'd0, 32'd3, 32'd4);

      // Randomized ops against the model.
      for (int i = 0; i < 60; i++) begin
         f7 = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(2, 127)) : 7'h01;
         run_op($sformatf("rnd%0d", i), f7, 3'($urandom), pick_operand(), pick_operand());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
